// File: rtl/delay_line_pkg.sv
// Shared definitions for the programmable delay line: FSM state encoding and a
// width helper.
package delay_line_pkg;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/delay_line_prog_if.sv
// Sample/control bundle of the delay line; the datapath owner uses the slave view.
interface delay_line_prog_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
);
    logic                  en;
    logic [DATA_WIDTH-1:0] din;
    logic [ADDR_WIDTH-1:0] delay_in;
    logic                  delay_ld;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_valid;
    logic                  filling;
    logic [ADDR_WIDTH-1:0] delay_cur;

    modport master (
        output en, din, delay_in, delay_ld,
        input  dout, dout_valid, filling, delay_cur
    );

    modport slave (
        input  en, din, delay_in, delay_ld,
        output dout, dout_valid, filling, delay_cur
    );
endinterface

// File: rtl/delay_ram.sv
// Simple dual-port sample buffer: synchronous write, registered read gated by re.
module delay_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Only the read register is cleared so dout reads 0 after reset; storage is not.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/delay_line_prog.sv
// Runtime-programmable, enable-gated delay line on a circular RAM buffer with
// flush-on-reload and a valid flag that masks stale samples.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  ST_FILL | fewer than delay_cur samples written since flush; dout stale
//  ST_RUN  | dout carries samples written since the last flush
module delay_line_prog
    import delay_line_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 4,
    parameter int RESET_DELAY = 0
) (
    input logic                clk,
    input logic                rst,
    delay_line_prog_if.slave   bus
);
    state_t                state, state_nx;
    logic                  valid_q, valid_nx;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] fill_cnt;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH-1:0] delay_q;
    logic                  byp_sel;
    logic [DATA_WIDTH-1:0] byp_data;
    logic [DATA_WIDTH-1:0] ram_q;
    logic                  ram_re;

    assign rd_addr = wr_ptr - delay_q;
    // With D=0 the read address equals the write address; the bypass path serves it instead.
    assign ram_re  = bus.en && (delay_q != '0);

    delay_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (bus.en && !rst),
        .waddr (wr_ptr),
        .wdata (bus.din),
        .re    (ram_re),
        .raddr (rd_addr),
        .rdata (ram_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_FILL;
            valid_q  <= 1'b0;
            wr_ptr   <= '0;
            fill_cnt <= '0;
            delay_q  <= ADDR_WIDTH'(RESET_DELAY);
            byp_sel  <= 1'b0;
            byp_data <= '0;
        end else begin
            state   <= state_nx;
            valid_q <= valid_nx;
            if (bus.en) begin
                wr_ptr   <= wr_ptr + ADDR_WIDTH'(1);
                byp_sel  <= (delay_q == '0);
                byp_data <= bus.din;
            end
            if (bus.delay_ld) begin
                fill_cnt <= '0;
                delay_q  <= bus.delay_in;
            end else if (bus.en && (fill_cnt != {ADDR_WIDTH{1'b1}})) begin
                fill_cnt <= fill_cnt + ADDR_WIDTH'(1);
            end
        end
    end

    // Valid rises on the same edge that moves the first post-flush sample onto dout.
    always_comb begin
        state_nx = state;
        valid_nx = valid_q;
        if (bus.en) begin
            case (state)
                ST_FILL: begin
                    if (fill_cnt >= delay_q) begin
                        state_nx = ST_RUN;
                        valid_nx = 1'b1;
                    end else begin
                        valid_nx = 1'b0;
                    end
                end
                ST_RUN:  valid_nx = 1'b1;
                default: begin
                    state_nx = ST_FILL;
                    valid_nx = 1'b0;
                end
            endcase
        end
        if (bus.delay_ld) begin
            state_nx = ST_FILL;
            valid_nx = 1'b0;
        end
    end

    assign bus.dout       = byp_sel ? byp_data : ram_q;
    assign bus.dout_valid = valid_q;
    assign bus.filling    = (state == ST_FILL);
    assign bus.delay_cur  = delay_q;
endmodule
